// File: rtl/panel_scan_ctrl.sv
// panel_scan_ctrl: HUB75-style LED panel scanner driving binary-coded
// bit-planes fetched one column at a time from a synchronous framebuffer.
module panel_scan_ctrl #(
   parameter int COLS     = 32,
   parameter int ROW_BITS = 4,
   parameter int DEPTH    = 4,
   parameter int ON_BASE  = 8
) (
   input  logic                             clk,
   input  logic                             resetn,
   input  logic                             enable,
   output logic                             fb_rd,
   output logic [ROW_BITS+$clog2(COLS)-1:0] fb_addr,
   input  logic [6*DEPTH-1:0]               fb_data,
   output logic                             PANEL_R0,
   output logic                             PANEL_G0,
   output logic                             PANEL_B0,
   output logic                             PANEL_R1,
   output logic                             PANEL_G1,
   output logic                             PANEL_B1,
   output logic                             PANEL_A,
   output logic                             PANEL_B,
   output logic                             PANEL_C,
   output logic                             PANEL_D,
   output logic                             PANEL_CLK,
   output logic                             PANEL_STB,
   output logic                             PANEL_OE,
   output logic                             busy,
   output logic                             frame_done
);
   localparam int CW = $clog2(COLS);
   localparam int AW = ROW_BITS + CW;
   localparam int SW = $clog2(2*COLS + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int DW = $clog2((ON_BASE << (DEPTH-1)) + 1);
   localparam logic [SW-1:0] SLAST  = SW'(2*COLS);
   localparam logic [SW-1:0] SRDEND = SW'(2*COLS - 2);
   localparam logic [DW-1:0] ONB    = DW'(ON_BASE);
   localparam logic [PW-1:0] PLAST  = PW'(DEPTH - 1);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_LATCH, S_DISP} state_t;

   state_t              r_state, w_state;
   logic [ROW_BITS-1:0] r_row, w_row;
   logic [PW-1:0]       r_plane, w_plane;
   logic [SW-1:0]       r_scnt, w_scnt;
   logic [DW-1:0]       r_dcnt, w_dcnt;
   logic                r_rd, w_rd;
   logic [AW-1:0]       r_addr, w_addr;
   logic [5:0]          r_px, w_px;
   logic [3:0]          r_rsel, w_rsel;
   logic                r_pclk, w_pclk;
   logic                r_stb, w_stb;
   logic                r_oe, w_oe;
   logic                r_busy, w_busy;
   logic                r_done, w_done;
   logic [CW-1:0]       w_col;
   logic [DEPTH-1:0]    w_fld;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= S_IDLE;
         r_row   <= '0;
         r_plane <= '0;
         r_scnt  <= '0;
         r_dcnt  <= '0;
         r_rd    <= 1'b0;
         r_addr  <= '0;
         r_px    <= '0;
         r_rsel  <= '0;
         r_pclk  <= 1'b0;
         r_stb   <= 1'b0;
         r_oe    <= 1'b1;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state;
         r_row   <= w_row;
         r_plane <= w_plane;
         r_scnt  <= w_scnt;
         r_dcnt  <= w_dcnt;
         r_rd    <= w_rd;
         r_addr  <= w_addr;
         r_px    <= w_px;
         r_rsel  <= w_rsel;
         r_pclk  <= w_pclk;
         r_stb   <= w_stb;
         r_oe    <= w_oe;
         r_busy  <= w_busy;
         r_done  <= w_done;
      end
   end

   // Every output is computed one cycle ahead so it leaves a flop.
   always_comb begin
      w_state = r_state;
      w_row   = r_row;
      w_plane = r_plane;
      w_scnt  = r_scnt;
      w_dcnt  = r_dcnt;
      w_rd    = 1'b0;
      w_addr  = r_addr;
      w_px    = r_px;
      w_rsel  = r_rsel;
      w_pclk  = 1'b0;
      w_stb   = 1'b0;
      w_oe    = 1'b1;
      w_done  = 1'b0;
      w_fld   = '0;
      w_col   = CW'(r_scnt >> 1) + CW'(1);
      unique case (r_state)
         S_IDLE: begin
            if (enable) begin
               w_state = S_SHIFT;
               w_row   = '0;
               w_plane = '0;
               w_scnt  = '0;
               w_rd    = 1'b1;
               w_addr  = '0;
            end
         end
         S_SHIFT: begin
            w_scnt = r_scnt + SW'(1);
            if (r_scnt == SLAST) begin
               w_state = S_LATCH;
               w_stb   = 1'b1;
               w_rsel  = 4'(r_row);
            end else if (r_scnt[0]) begin
               w_pclk = 1'b1;
               for (int k = 0; k < 6; k++) begin
                  w_fld   = fb_data[k*DEPTH +: DEPTH];
                  w_px[k] = w_fld[r_plane];
               end
            end else if (r_scnt < SRDEND) begin
               w_rd   = 1'b1;
               w_addr = {r_row, w_col};
            end
         end
         S_LATCH: begin
            w_state = S_DISP;
            w_oe    = 1'b0;
            w_dcnt  = (ONB << r_plane) - DW'(1);
         end
         S_DISP: begin
            if (r_dcnt != '0) begin
               w_dcnt = r_dcnt - DW'(1);
               w_oe   = 1'b0;
            end else begin
               if (r_plane == PLAST) begin
                  w_plane = '0;
                  w_row   = r_row + ROW_BITS'(1);
                  w_done  = (r_row == '1);
               end else begin
                  w_plane = r_plane + PW'(1);
               end
               if (enable) begin
                  w_state = S_SHIFT;
                  w_scnt  = '0;
                  w_rd    = 1'b1;
                  w_addr  = {w_row, {CW{1'b0}}};
               end else begin
                  w_state = S_IDLE;
               end
            end
         end
      endcase
      w_busy = (w_state != S_IDLE);
   end

   assign fb_rd      = r_rd;
   assign fb_addr    = r_addr;
   assign PANEL_R0   = r_px[0];
   assign PANEL_G0   = r_px[1];
   assign PANEL_B0   = r_px[2];
   assign PANEL_R1   = r_px[3];
   assign PANEL_G1   = r_px[4];
   assign PANEL_B1   = r_px[5];
   assign PANEL_A    = r_rsel[0];
   assign PANEL_B    = r_rsel[1];
   assign PANEL_C    = r_rsel[2];
   assign PANEL_D    = r_rsel[3];
   assign PANEL_CLK  = r_pclk;
   assign PANEL_STB  = r_stb;
   assign PANEL_OE   = r_oe;
   assign busy       = r_busy;
   assign frame_done = r_done;

endmodule

// File: tb/tb_panel_scan_ctrl.sv
// tb_panel_scan_ctrl: scenario tasks with a queue scoreboard for the
// panel scanner, driven from a synchronous model framebuffer.
module tb_panel_scan_ctrl;
   localparam int COLS     = 32;
   localparam int ROW_BITS = 4;
   localparam int DEPTH    = 4;
   localparam int ON_BASE  = 8;
   localparam int AW       = ROW_BITS + $clog2(COLS);

   logic clk = 1'b0;
   logic resetn = 1'b1;
   logic enable = 1'b0;
   logic fb_rd;
   logic [AW-1:0] fb_addr;
   logic [6*DEPTH-1:0] fb_data;
   logic r0, g0, b0, r1, g1, b1;
   logic pa, pb, pc, pd;
   logic pclk, pstb, poe, busy, frame_done;
   logic [3:0] rows;
   logic [5:0] px;

   logic [6*DEPTH-1:0] mem [0:(1<<AW)-1];
   int n_pass = 0;
   int n_total = 0;
   int q_addr[$];
   logic [5:0] q_px[$];
   int q_int[$];

   panel_scan_ctrl #(
      .COLS(COLS), .ROW_BITS(ROW_BITS), .DEPTH(DEPTH), .ON_BASE(ON_BASE)
   ) dut (
      .clk(clk), .resetn(resetn), .enable(enable),
      .fb_rd(fb_rd), .fb_addr(fb_addr), .fb_data(fb_data),
      .PANEL_R0(r0), .PANEL_G0(g0), .PANEL_B0(b0),
      .PANEL_R1(r1), .PANEL_G1(g1), .PANEL_B1(b1),
      .PANEL_A(pa), .PANEL_B(pb), .PANEL_C(pc), .PANEL_D(pd),
      .PANEL_CLK(pclk), .PANEL_STB(pstb), .PANEL_OE(poe),
      .busy(busy), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (fb_rd) fb_data <= mem[fb_addr];

   assign rows = {pd, pc, pb, pa};
   assign px   = {b1, g1, r1, b0, g0, r0};

   function automatic logic [5:0] px_of(input logic [6*DEPTH-1:0] w,
                                        input int p);
      logic [6*DEPTH-1:0] t;
      px_of = '0;
      for (int k = 0; k < 6; k++) begin
         t = w >> (k*DEPTH + p);
         px_of[k] = t[0];
      end
   endfunction

   task automatic do_reset();
      enable = 1'b0;
      @(negedge clk);
      resetn = 1'b0;
      repeat (2) @(negedge clk);
      resetn = 1'b1;
   endtask

   task automatic test_reset();
      int bad = 0;
      #1 resetn = 1'b0;
      #1;
      n_total++;
      if (poe !== 1'b1 || busy !== 1'b0 || fb_rd !== 1'b0 || rows !== 4'd0)
         $display("FAIL reset_async: oe=%b busy=%b rd=%b rows=%0d want 1 0 0 0",
                  poe, busy, fb_rd, rows);
      else n_pass++;
      n_total++;
      if (pclk !== 1'b0 || pstb !== 1'b0 || frame_done !== 1'b0 ||
          fb_addr !== '0 || px !== 6'd0)
         $display("FAIL reset_others: clk=%b stb=%b fd=%b addr=%0d px=%b want zeros",
                  pclk, pstb, frame_done, fb_addr, px);
      else n_pass++;
      @(negedge clk);
      resetn = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (busy !== 1'b0 || poe !== 1'b1 || fb_rd !== 1'b0) bad++;
      end
      n_total++;
      if (bad != 0)
         $display("FAIL idle_hold: %0d bad cycles, want 0", bad);
      else n_pass++;
   endtask

   task automatic test_shift_timing();
      int clks = 0, rds = 0, stbs = 0, oelow = 0, cyc = 0, t1 = 0, t2 = 0;
      int ea;
      logic [5:0] ep;
      logic pclk_q = 1'b0;
      bit done = 0;
      do_reset();
      for (int a = 0; a < (1<<AW); a++) mem[a] = (6*DEPTH)'($urandom);
      q_addr.delete();
      q_px.delete();
      for (int c = 0; c < COLS; c++) begin
         q_addr.push_back(c);
         q_px.push_back(px_of(mem[c], 0));
      end
      enable = 1'b1;
      for (int i = 0; i < 400 && !done; i++) begin
         @(negedge clk);
         cyc++;
         if (stbs == 0) begin
            if (fb_rd) begin
               rds++;
               n_total++;
               if (q_addr.size() == 0)
                  $display("FAIL shift_addr: extra read addr=%0d", fb_addr);
               else begin
                  ea = q_addr.pop_front();
                  if (fb_addr !== AW'(ea))
                     $display("FAIL shift_addr: got %0d want %0d", fb_addr, ea);
                  else n_pass++;
               end
            end
            if (pclk && !pclk_q) begin
               clks++;
               n_total++;
               if (q_px.size() == 0)
                  $display("FAIL shift_px: extra clock px=%b", px);
               else begin
                  ep = q_px.pop_front();
                  if (px !== ep || poe !== 1'b1)
                     $display("FAIL shift_px: col %0d px=%b oe=%b want %b oe=1",
                              clks-1, px, poe, ep);
                  else n_pass++;
               end
            end
         end
         if (pstb) begin
            stbs++;
            if (stbs == 1) begin
               t1 = cyc;
               n_total++;
               if (rows !== 4'd0 || poe !== 1'b1 || pclk !== 1'b0)
                  $display("FAIL latch_state: rows=%0d oe=%b clk=%b want 0 1 0",
                           rows, poe, pclk);
               else n_pass++;
            end else begin
               t2 = cyc;
               done = 1;
            end
         end
         if (stbs == 1 && !poe) oelow++;
         pclk_q = pclk;
      end
      enable = 1'b0;
      n_total++;
      if (!done) $display("FAIL shift_timeout: stbs=%0d want 2", stbs);
      else n_pass++;
      n_total++;
      if (clks != COLS || rds != COLS)
         $display("FAIL shift_counts: clks=%0d reads=%0d want %0d", clks, rds, COLS);
      else n_pass++;
      n_total++;
      if (oelow != ON_BASE)
         $display("FAIL oe_low_p0: got %0d want %0d", oelow, ON_BASE);
      else n_pass++;
      n_total++;
      if (t2 - t1 != 2*COLS + 2 + ON_BASE)
         $display("FAIL stb_period: got %0d want %0d", t2 - t1, 2*COLS + 2 + ON_BASE);
      else n_pass++;
   endtask

   task automatic test_plane_mapping();
      int run = 0, planes = 0, ed;
      logic [5:0] ep;
      do_reset();
      for (int a = 0; a < (1<<AW); a++) mem[a] = 24'h00000A;
      q_px.delete();
      q_int.delete();
      for (int p = 0; p < DEPTH; p++) begin
         q_px.push_back(px_of(24'h00000A, p));
         q_int.push_back(ON_BASE << p);
      end
      enable = 1'b1;
      for (int i = 0; i < 1000 && planes < DEPTH; i++) begin
         @(negedge clk);
         if (pstb && q_px.size() != 0) begin
            ep = q_px.pop_front();
            n_total++;
            if (px !== ep)
               $display("FAIL plane_px: plane %0d px=%b want %b", planes, px, ep);
            else n_pass++;
         end
         if (!poe) run++;
         else if (run > 0) begin
            ed = q_int.pop_front();
            n_total++;
            if (run != ed)
               $display("FAIL plane_oe: plane %0d low=%0d want %0d", planes, run, ed);
            else n_pass++;
            run = 0;
            planes++;
         end
      end
      enable = 1'b0;
      n_total++;
      if (planes != DEPTH)
         $display("FAIL plane_timeout: planes=%0d want %0d", planes, DEPTH);
      else n_pass++;
   endtask

   task automatic test_row_frame();
      int stbs = 0, fd = 0, fd_stb = -1, er;
      bit fd_ok = 0;
      logic oe_q = 1'b1;
      do_reset();
      q_int.delete();
      for (int r = 0; r < (1<<ROW_BITS); r++)
         for (int p = 0; p < DEPTH; p++) q_int.push_back(r);
      q_int.push_back(0);
      enable = 1'b1;
      for (int i = 0; i < 7000 && q_int.size() != 0; i++) begin
         @(negedge clk);
         if (pstb) begin
            stbs++;
            er = q_int.pop_front();
            n_total++;
            if (rows !== 4'(er))
               $display("FAIL row_seq: stb %0d rows=%0d want %0d", stbs, rows, er);
            else n_pass++;
         end
         if (frame_done) begin
            fd++;
            fd_stb = stbs;
            fd_ok = (oe_q == 1'b0 && poe == 1'b1);
         end
         oe_q = poe;
      end
      enable = 1'b0;
      n_total++;
      if (q_int.size() != 0)
         $display("FAIL row_timeout: %0d STBs missing", q_int.size());
      else n_pass++;
      n_total++;
      if (fd != 1 || fd_stb != (1<<ROW_BITS)*DEPTH || !fd_ok)
         $display("FAIL frame_done: pulses=%0d after_stb=%0d edge_ok=%0d want 1 %0d 1",
                  fd, fd_stb, fd_ok, (1<<ROW_BITS)*DEPTH);
      else n_pass++;
   endtask

   task automatic test_enable_drop();
      int clks = 0, stbs = 0, run = 0, quiet = 0, eclk, edur;
      logic pclk_q = 1'b0;
      bit ended = 0;
      do_reset();
      q_int.delete();
      q_int.push_back(COLS);
      q_int.push_back(ON_BASE);
      enable = 1'b1;
      for (int i = 0; i < 300 && !ended; i++) begin
         @(negedge clk);
         if (pclk && !pclk_q) begin
            clks++;
            if (clks == 10) enable = 1'b0;
         end
         if (pstb) stbs++;
         if (!poe) run++;
         else if (run > 0) begin
            ended = 1;
            n_total++;
            if (busy !== 1'b0)
               $display("FAIL drop_busy: busy=%b want 0", busy);
            else n_pass++;
         end
         pclk_q = pclk;
      end
      eclk = q_int.pop_front();
      edur = q_int.pop_front();
      n_total++;
      if (!ended || clks != eclk || stbs != 1 || run != edur)
         $display("FAIL drop_plane: ended=%0d clks=%0d stbs=%0d low=%0d want 1 %0d 1 %0d",
                  ended, clks, stbs, run, eclk, edur);
      else n_pass++;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (busy || fb_rd || pclk || pstb || !poe) quiet++;
      end
      n_total++;
      if (quiet != 0)
         $display("FAIL drop_idle: %0d active cycles, want 0", quiet);
      else n_pass++;
   endtask

   task automatic test_reset_mid_display();
      int stbs = 0, run = 0, er;
      bit hit = 0, rd_seen = 0, stb_seen = 0, done = 0;
      do_reset();
      q_int.delete();
      q_int.push_back(1);
      q_int.push_back(0);
      q_int.push_back(ON_BASE);
      enable = 1'b1;
      for (int i = 0; i < 1000 && !hit; i++) begin
         @(negedge clk);
         if (pstb) begin
            stbs++;
            if (stbs == 6) begin
               hit = 1;
               er = q_int.pop_front();
               n_total++;
               if (rows !== 4'(er))
                  $display("FAIL pre_reset_row: rows=%0d want %0d", rows, er);
               else n_pass++;
            end
         end
      end
      repeat (3) @(negedge clk);
      n_total++;
      if (!hit || poe !== 1'b0)
         $display("FAIL pre_reset_disp: hit=%0d oe=%b want 1 0", hit, poe);
      else n_pass++;
      #2 resetn = 1'b0;
      #1;
      n_total++;
      if (poe !== 1'b1 || busy !== 1'b0 || fb_rd !== 1'b0 || rows !== 4'd0)
         $display("FAIL mid_reset_async: oe=%b busy=%b rd=%b rows=%0d want 1 0 0 0",
                  poe, busy, fb_rd, rows);
      else n_pass++;
      @(negedge clk);
      resetn = 1'b1;
      #1;
      n_total++;
      if (busy !== 1'b0 || fb_rd !== 1'b0)
         $display("FAIL early_start: busy=%b rd=%b want 0 0", busy, fb_rd);
      else n_pass++;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk);
         if (fb_rd && !rd_seen) begin
            rd_seen = 1;
            n_total++;
            if (fb_addr !== '0)
               $display("FAIL restart_addr: got %0d want 0", fb_addr);
            else n_pass++;
         end
         if (pstb && !stb_seen) begin
            stb_seen = 1;
            er = q_int.pop_front();
            n_total++;
            if (rows !== 4'(er))
               $display("FAIL restart_row: rows=%0d want %0d", rows, er);
            else n_pass++;
         end
         if (!poe) run++;
         else if (run > 0) begin
            done = 1;
            er = q_int.pop_front();
            n_total++;
            if (run != er)
               $display("FAIL restart_plane: low=%0d want %0d", run, er);
            else n_pass++;
         end
      end
      enable = 1'b0;
      n_total++;
      if (!done) $display("FAIL restart_timeout: no display after restart");
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_shift_timing();
      test_plane_mapping();
      test_row_frame();
      test_enable_drop();
      test_reset_mid_display();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
